tdm_demux: RTL and testbench



---
 rtl/tdm_demux_if.sv | 35 +++
 rtl/tdm_demux.sv | 129 ++++++++++++
 tb/tb_tdm_demux.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// Bus bundle for the TDM demultiplexer: serial word input side and parallel frame output side.
// ERR_CNT exists only when TDM_DEMUX_ERRCNT_EN is defined.
interface tdm_demux_if #(
    parameter int N_CH = 4,
    parameter int W    = 8
);
    localparam int CW = $clog2(N_CH);

    logic [W-1:0]      DIN;
    logic              DIN_VLD;
    logic              FSYNC;
    logic [N_CH*W-1:0] Y;
    logic              Y_VLD;
    logic [CW-1:0]     CH;
    logic              SYNC_ERR;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0]        ERR_CNT;
`endif

    modport master (
        output DIN, DIN_VLD, FSYNC,
`ifdef TDM_DEMUX_ERRCNT_EN
        input  ERR_CNT,
`endif
        input  Y, Y_VLD, CH, SYNC_ERR
    );

    modport slave (
        input  DIN, DIN_VLD, FSYNC,
`ifdef TDM_DEMUX_ERRCNT_EN
        output ERR_CNT,
`endif
        output Y, Y_VLD, CH, SYNC_ERR
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM demultiplexer: de-interleaves N_CH channels into a parallel frame with a one-cycle valid.
// Optional saturating framing-error counter enabled by macro TDM_DEMUX_ERRCNT_EN.
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    tdm_demux_if.slave bus
);
    localparam int          CW      = $clog2(N_CH);
    localparam logic [CW-1:0] CH_LAST = CW'(N_CH - 1);

    typedef enum logic {S_HUNT, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_ch;
    logic [CW-1:0]     w_ch_nxt;
    logic [W-1:0]      r_sh [N_CH-1];
    logic [N_CH*W-1:0] r_y;
    logic              r_y_vld;
    logic              r_sync_err;
    logic              w_wr;
    logic [CW-1:0]     w_wr_idx;
    logic              w_done;
    logic              w_err;
    logic [N_CH*W-1:0] w_frame;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_HUNT;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    // Only the channel-0-qualified word may start or restart a frame.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_wr        = 1'b0;
        w_wr_idx    = r_ch;
        w_done      = 1'b0;
        w_err       = 1'b0;
        if (bus.DIN_VLD) begin
            case (r_state)
                S_HUNT: begin
                    if (bus.FSYNC) begin
                        w_wr        = 1'b1;
                        w_wr_idx    = '0;
                        w_ch_nxt    = CW'(1);
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.FSYNC) begin
                        w_err    = (r_ch != '0);
                        w_wr     = 1'b1;
                        w_wr_idx = '0;
                        w_ch_nxt = CW'(1);
                    end else if (r_ch == '0) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_HUNT;
                    end else if (r_ch == CH_LAST) begin
                        w_done   = 1'b1;
                        w_ch_nxt = '0;
                    end else begin
                        w_wr     = 1'b1;
                        w_ch_nxt = r_ch + CW'(1);
                    end
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    // The last channel goes straight from DIN into Y, so it needs no shadow slot.
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < N_CH - 1; k++) begin
            w_frame[k*W +: W] = r_sh[k];
        end
        w_frame[(N_CH-1)*W +: W] = bus.DIN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < N_CH - 1; k++) begin
                r_sh[k] <= '0;
            end
            r_y        <= '0;
            r_y_vld    <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH - 1; k++) begin
                if (w_wr && (w_wr_idx == CW'(k))) begin
                    r_sh[k] <= bus.DIN;
                end
            end
            if (w_done) begin
                r_y <= w_frame;
            end
            r_y_vld    <= w_done;
            r_sync_err <= w_err;
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.ERR_CNT = r_err_cnt;
`endif

    assign bus.Y        = r_y;
    assign bus.Y_VLD    = r_y_vld;
    assign bus.CH       = r_ch;
    assign bus.SYNC_ERR = r_sync_err;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with N_CH=4, W=8.
module tb_tdm_demux;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    tdm_demux_if #(.N_CH(4), .W(8)) bus ();

    tdm_demux #(.N_CH(4), .W(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input logic [7:0] d, input logic v, input logic f);
        bus.DIN     = d;
        bus.DIN_VLD = v;
        bus.FSYNC   = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.DIN = 8'h00; bus.DIN_VLD = 1'b0; bus.FSYNC = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.Y !== 32'h0) begin errors++; $display("FAIL rst_y: got %h expected %h", bus.Y, 32'h0); end
        checks++; if (bus.Y_VLD !== 1'b0) begin errors++; $display("FAIL rst_yvld: got %b expected 0", bus.Y_VLD); end
        checks++; if (bus.CH !== 2'd0) begin errors++; $display("FAIL rst_ch: got %0d expected 0", bus.CH); end
        checks++; if (bus.SYNC_ERR !== 1'b0) begin errors++; $display("FAIL rst_serr: got %b expected 0", bus.SYNC_ERR); end
`ifdef TDM_DEMUX_ERRCNT_EN
        checks++; if (bus.ERR_CNT !== 8'd0) begin errors++; $display("FAIL rst_errcnt: got %0d expected 0", bus.ERR_CNT); end
`endif
        rst = 1'b0;
        step(8'h11, 1'b1, 1'b0);
        step(8'h22, 1'b1, 1'b0);
        checks++; if (bus.SYNC_ERR !== 1'b0) begin errors++; $display("FAIL hunt_serr: got %b expected 0", bus.SYNC_ERR); end
        checks++; if (bus.Y_VLD !== 1'b0) begin errors++; $display("FAIL hunt_yvld: got %b expected 0", bus.Y_VLD); end
        checks++; if (bus.CH !== 2'd0) begin errors++; $display("FAIL hunt_ch: got %0d expected 0", bus.CH); end
        checks++; if (bus.Y !== 32'h0) begin errors++; $display("FAIL hunt_y: got %h expected %h", bus.Y, 32'h0); end
    endtask

    task automatic test_nominal;
        step(8'hA0, 1'b1, 1'b1);
        checks++; if (bus.CH !== 2'd1) begin errors++; $display("FAIL nom_ch1: got %0d expected 1", bus.CH); end
        step(8'hA1, 1'b1, 1'b0);
        step(8'hA2, 1'b1, 1'b0);
        checks++; if (bus.CH !== 2'd3 || bus.Y_VLD !== 1'b0) begin errors++; $display("FAIL nom_ch3: got ch=%0d vld=%b expected ch=3 vld=0", bus.CH, bus.Y_VLD); end
        step(8'hA3, 1'b1, 1'b0);
        checks++; if (bus.Y_VLD !== 1'b1) begin errors++; $display("FAIL nom_yvld: got %b expected 1", bus.Y_VLD); end
        checks++; if (bus.Y !== 32'hA3A2A1A0) begin errors++; $display("FAIL nom_y: got %h expected %h", bus.Y, 32'hA3A2A1A0); end
        checks++; if (bus.CH !== 2'd0) begin errors++; $display("FAIL nom_wrap: got %0d expected 0", bus.CH); end
        step(8'hB0, 1'b1, 1'b1);
        checks++; if (bus.Y_VLD !== 1'b0 || bus.Y !== 32'hA3A2A1A0) begin errors++; $display("FAIL nom_hold: got vld=%b y=%h expected vld=0 y=a3a2a1a0", bus.Y_VLD, bus.Y); end
        step(8'hB1, 1'b1, 1'b0);
        step(8'hB2, 1'b1, 1'b0);
        checks++; if (bus.Y_VLD !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b expected 0", bus.Y_VLD); end
        step(8'hB3, 1'b1, 1'b0);
        checks++; if (bus.Y_VLD !== 1'b1 || bus.Y !== 32'hB3B2B1B0) begin errors++; $display("FAIL b2b_frame: got vld=%b y=%h expected vld=1 y=b3b2b1b0", bus.Y_VLD, bus.Y); end
        step(8'h00, 1'b0, 1'b0);
        checks++; if (bus.Y_VLD !== 1'b0) begin errors++; $display("FAIL nom_pulse: got %b expected 0", bus.Y_VLD); end
    endtask

    task automatic test_gaps;
        logic [7:0] words [4];
        int         vld_seen;
        words[0] = 8'hA0; words[1] = 8'hA1; words[2] = 8'hA2; words[3] = 8'hA3;
        vld_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(words[i], 1'b1, (i == 0));
            if (bus.Y_VLD === 1'b1) vld_seen++;
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step(8'h5A, 1'b0, (g == 1));
                    if (bus.Y_VLD === 1'b1) vld_seen++;
                end
                checks++; if (bus.CH !== 2'(i + 1)) begin errors++; $display("FAIL gap_ch%0d: got %0d expected %0d", i, bus.CH, i + 1); end
            end
        end
        checks++; if (bus.Y !== 32'hA3A2A1A0) begin errors++; $display("FAIL gap_y: got %h expected %h", bus.Y, 32'hA3A2A1A0); end
        checks++; if (vld_seen != 1) begin errors++; $display("FAIL gap_vldcnt: got %0d expected 1", vld_seen); end
    endtask

    task automatic test_early_sync;
        int vld_seen;
        vld_seen = 0;
        step(8'hC0, 1'b1, 1'b1);
        step(8'hC1, 1'b1, 1'b0);
        checks++; if (bus.SYNC_ERR !== 1'b0) begin errors++; $display("FAIL es_pre: got %b expected 0", bus.SYNC_ERR); end
        step(8'hD0, 1'b1, 1'b1);
        checks++; if (bus.SYNC_ERR !== 1'b1 || bus.CH !== 2'd1) begin errors++; $display("FAIL es_err: got serr=%b ch=%0d expected serr=1 ch=1", bus.SYNC_ERR, bus.CH); end
        if (bus.Y_VLD === 1'b1) vld_seen++;
        step(8'hD1, 1'b1, 1'b0);
        checks++; if (bus.SYNC_ERR !== 1'b0) begin errors++; $display("FAIL es_pulse: got %b expected 0", bus.SYNC_ERR); end
        if (bus.Y_VLD === 1'b1) vld_seen++;
        step(8'hD2, 1'b1, 1'b0);
        if (bus.Y_VLD === 1'b1) vld_seen++;
        step(8'hD3, 1'b1, 1'b0);
        if (bus.Y_VLD === 1'b1) vld_seen++;
        checks++; if (bus.Y !== 32'hD3D2D1D0) begin errors++; $display("FAIL es_y: got %h expected %h", bus.Y, 32'hD3D2D1D0); end
        checks++; if (vld_seen != 1) begin errors++; $display("FAIL es_vldcnt: got %0d expected 1", vld_seen); end
    endtask

    task automatic test_missing_sync;
        step(8'h30, 1'b1, 1'b1);
        step(8'h31, 1'b1, 1'b0);
        step(8'h32, 1'b1, 1'b0);
        step(8'h33, 1'b1, 1'b0);
        checks++; if (bus.Y !== 32'h33323130) begin errors++; $display("FAIL ms_frame: got %h expected %h", bus.Y, 32'h33323130); end
        step(8'hE0, 1'b1, 1'b0);
        checks++; if (bus.SYNC_ERR !== 1'b1 || bus.CH !== 2'd0) begin errors++; $display("FAIL ms_err: got serr=%b ch=%0d expected serr=1 ch=0", bus.SYNC_ERR, bus.CH); end
        step(8'h55, 1'b1, 1'b0);
        checks++; if (bus.SYNC_ERR !== 1'b0 || bus.CH !== 2'd0) begin errors++; $display("FAIL ms_hunt: got serr=%b ch=%0d expected serr=0 ch=0", bus.SYNC_ERR, bus.CH); end
        step(8'hF0, 1'b1, 1'b1);
        step(8'hF1, 1'b1, 1'b0);
        step(8'hF2, 1'b1, 1'b0);
        step(8'hF3, 1'b1, 1'b0);
        checks++; if (bus.Y_VLD !== 1'b1 || bus.Y !== 32'hF3F2F1F0) begin errors++; $display("FAIL ms_resume: got vld=%b y=%h expected vld=1 y=f3f2f1f0", bus.Y_VLD, bus.Y); end
`ifdef TDM_DEMUX_ERRCNT_EN
        checks++; if (bus.ERR_CNT !== 8'd2) begin errors++; $display("FAIL cnt_two: got %0d expected 2", bus.ERR_CNT); end
        step(8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(8'h02, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0);
        checks++; if (bus.ERR_CNT !== 8'd255) begin errors++; $display("FAIL cnt_sat: got %0d expected 255", bus.ERR_CNT); end
        step(8'h01, 1'b1, 1'b0);
        step(8'h02, 1'b1, 1'b0);
        step(8'h03, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_reset_midframe;
        int vld_seen;
        vld_seen = 0;
        step(8'h10, 1'b1, 1'b1);
        step(8'h11, 1'b1, 1'b0);
        bus.DIN_VLD = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.Y !== 32'h0 || bus.CH !== 2'd0 || bus.Y_VLD !== 1'b0 || bus.SYNC_ERR !== 1'b0) begin errors++; $display("FAIL rmid_async: got y=%h ch=%0d vld=%b serr=%b expected all zero", bus.Y, bus.CH, bus.Y_VLD, bus.SYNC_ERR); end
`ifdef TDM_DEMUX_ERRCNT_EN
        checks++; if (bus.ERR_CNT !== 8'd0) begin errors++; $display("FAIL rmid_cnt: got %0d expected 0", bus.ERR_CNT); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'h12, 1'b1, 1'b0);
        step(8'h13, 1'b1, 1'b0);
        checks++; if (bus.Y_VLD !== 1'b0 || bus.SYNC_ERR !== 1'b0 || bus.CH !== 2'd0) begin errors++; $display("FAIL rmid_lost: got vld=%b serr=%b ch=%0d expected 0 0 0", bus.Y_VLD, bus.SYNC_ERR, bus.CH); end
        for (int i = 0; i < 4; i++) begin
            step(8'h20 + 8'(i), 1'b1, (i == 0));
            if (bus.Y_VLD === 1'b1) vld_seen++;
        end
        checks++; if (bus.Y !== 32'h23222120 || vld_seen != 1) begin errors++; $display("FAIL rmid_frame: got y=%h vlds=%0d expected y=23222120 vlds=1", bus.Y, vld_seen); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_nominal();
        test_gaps();
        test_early_sync();
        test_missing_sync();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
